d_hazard_scoreboard: RTL and testbench
======================================

Name: d_hazard_scoreboard

Overview:
- Stall-generation unit for the Decode stage of the 16-bit, 5-stage pipeline.
- Keeps a 2-entry shadow scoreboard of in-flight destination registers: the instructions now in EX and in MEM.
- Asserts a stall whenever a D-stage consumer needs a register value that the EX->D / MEM->D forwarding paths cannot yet supply.
- Sits beside the D-stage forwarding mux. It drives the PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- RET_REG, 3'h7, register written when wr_sel = 2'b11 (link register).
- CNT_W, 16, width of the stall performance counter (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- d_inst  in  16  instruction in D. Rs = [10:8], Rt = [7:5].
- d_valid  in  1  D holds a real instruction (not a bubble).
- d_early_rs  in  1  D instruction consumes Rs in D (branch, JR, JALR).
- d_reads_rs  in  1  D instruction consumes Rs in EX.
- d_reads_rt  in  1  D instruction consumes Rt in EX.
- d_reg_write  in  1  D instruction writes a register.
- d_wr_sel  in  2  destination select: 00 -> [7:5], 01 -> [4:2], 10 -> [10:8], 11 -> RET_REG.
- d_is_load  in  1  D instruction is a memory load.
- flush_d  in  1  D instruction is being squashed (taken branch or jump).
- mem_stall  in  1  memory busy; the whole pipeline freezes.
- stall_d  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_cnt  out  CNT_W  stalls counted (only with HAZ_PERF_CNT_EN).

Behaviour:
- State: two entries, EX and MEM. Each entry holds {valid, dest[2:0], is_load}.
- Reset (async, rst_n = 0): both entries invalid; stall_d = 0; stall_cnt = 0.
- D entry: valid = d_valid & d_reg_write & ~flush_d. dest is decoded from d_wr_sel / d_inst.
- Update on rising clk, in priority order:
  - mem_stall = 1: hold both entries.
  - else stall_d = 1: EX <= invalid (bubble); MEM <= EX.
  - else: EX <= D entry; MEM <= EX.
- Hazard terms (combinational; only valid entries match; register 0 is not special):
  - H1: d_early_rs & EX.valid & EX.dest == Rs. ALU result is not ready until EX completes.
  - H2: d_early_rs & MEM.valid & MEM.is_load & MEM.dest == Rs. Load data is only available from WB.
  - H3: (d_reads_rs & EX.dest == Rs | d_reads_rt & EX.dest == Rt) & EX.valid & EX.is_load. This is the load-use case.
- stall_d = d_valid & ~flush_d & (H1 | H2 | H3).
- Stall lengths produced by the shift behaviour (not by a counter):
  - Early-use after ALU op: 1 cycle.
  - Early-use after load: 2 cycles (H1, then H2).
  - Load-use in EX: 1 cycle.
- No hazard is flagged against an entry in WB; the WB->D forwarding path covers it.
- flush_d and stall_d never assert together.
- During mem_stall, stall_d keeps reflecting the frozen state. Downstream ORs it with mem_stall.
- Reset mid-stall: stall_d drops to 0 immediately (combinational from the cleared entries).

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each clk where stall_d = 1 and mem_stall = 0.
  - It saturates at all-ones.
  - It is cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Reset, then `ADD R3` (wr_sel 00, [7:5] = 3) followed by `BEQZ R3` (d_early_rs, Rs = 3) -> stall_d = 1 for exactly 1 cycle, then 0.
- `LD R2` (is_load) followed by `JR R2` -> stall_d = 1 for 2 consecutive cycles, then the branch proceeds.
- `LD R5` followed by `ADD` reading Rt = 5 -> 1-cycle stall. If `ADD` instead follows with one independent instruction between, no stall.
- `JAL` (wr_sel 11) followed by `JR R7` -> 1-cycle stall. With flush_d = 1 on the instruction after JAL -> no stall, and EX entry invalid next cycle.
- Load-use hazard pending, then mem_stall = 1 for 3 cycles -> entries held and stall_d stays 1. After release -> one bubble, then stall_d = 0.
- HAZ_PERF_CNT_EN defined: run the three hazard sequences above -> stall_cnt = 4. Then assert rst_n = 0 mid-stall -> stall_cnt = 0 and stall_d = 0 asynchronously.

Source files
------------

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage stall generator: tracks EX/MEM destination registers and flags hazards that
// forwarding cannot cover. Optional stall counter enabled by HAZ_PERF_CNT_EN.
module d_hazard_scoreboard #(
  parameter logic [2:0]  RET_REG = 3'h7,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      d_inst,
  input  logic             d_valid,
  input  logic             d_early_rs,
  input  logic             d_reads_rs,
  input  logic             d_reads_rt,
  input  logic             d_reg_write,
  input  logic [1:0]       d_wr_sel,
  input  logic             d_is_load,
  input  logic             flush_d,
  input  logic             mem_stall,
  output logic             stall_d,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       is_load;
  } entry_t;

  entry_t     ex_q, ex_d, mem_q, mem_d, d_entry;
  logic [2:0] rs, rt;
  logic       h1, h2, h3;
  logic       unused_inst;

  assign rs          = d_inst[10:8];
  assign rt          = d_inst[7:5];
  assign unused_inst = ^{d_inst[15:11], d_inst[1:0]};

  always_comb begin
    d_entry         = '0;
    d_entry.valid   = d_valid & d_reg_write & ~flush_d;
    d_entry.is_load = d_is_load;
    unique case (d_wr_sel)
      2'b00:   d_entry.dest = d_inst[7:5];
      2'b01:   d_entry.dest = d_inst[4:2];
      2'b10:   d_entry.dest = d_inst[10:8];
      default: d_entry.dest = RET_REG;
    endcase
  end

  // WB is deliberately absent: the WB->D forwarding path covers that distance.
  always_comb begin
    h1 = d_early_rs & ex_q.valid & (ex_q.dest == rs);
    h2 = d_early_rs & mem_q.valid & mem_q.is_load & (mem_q.dest == rs);
    h3 = ex_q.valid & ex_q.is_load &
         ((d_reads_rs & (ex_q.dest == rs)) | (d_reads_rt & (ex_q.dest == rt)));
    stall_d = d_valid & ~flush_d & (h1 | h2 | h3);
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!mem_stall) begin
      mem_d = ex_q;
      ex_d  = stall_d ? '0 : d_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of cycles in which a bubble is really inserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_d && !mem_stall && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Self-checking bench for d_hazard_scoreboard: per-cycle expected stall_d values are queued
// as each D-stage instruction is driven and compared at the following negedge.
module tb_d_hazard_scoreboard;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [15:0]      d_inst;
  logic             d_valid;
  logic             d_early_rs;
  logic             d_reads_rs;
  logic             d_reads_rt;
  logic             d_reg_write;
  logic [1:0]       d_wr_sel;
  logic             d_is_load;
  logic             flush_d;
  logic             mem_stall;
  logic             stall_d;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_q[$];

  typedef struct packed {
    logic [2:0] rs, rt, rd;
    logic       early, rrs, rrt, rw;
    logic [1:0] wsel;
    logic       load, flush, mstall, exp;
  } stim_t;

  d_hazard_scoreboard #(
    .RET_REG (3'h7),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_inst      (d_inst),
    .d_valid     (d_valid),
    .d_early_rs  (d_early_rs),
    .d_reads_rs  (d_reads_rs),
    .d_reads_rt  (d_reads_rt),
    .d_reg_write (d_reg_write),
    .d_wr_sel    (d_wr_sel),
    .d_is_load   (d_is_load),
    .flush_d     (flush_d),
    .mem_stall   (mem_stall),
    .stall_d     (stall_d),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Argument order: rs, rt, rd, early_rs, reads_rs, reads_rt, reg_write, wr_sel, load,
  // flush, mem_stall, expected stall_d.
  function automatic stim_t mk(input logic [2:0] rs, input logic [2:0] rt,
                               input logic [2:0] rd, input logic early, input logic rrs,
                               input logic rrt, input logic rw, input logic [1:0] wsel,
                               input logic load, input logic flush, input logic mstall,
                               input logic exp);
    stim_t s;
    s.rs = rs; s.rt = rt; s.rd = rd;
    s.early = early; s.rrs = rrs; s.rrt = rrt; s.rw = rw; s.wsel = wsel;
    s.load = load; s.flush = flush; s.mstall = mstall; s.exp = exp;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    d_inst      = {5'b0, s.rs, s.rt, s.rd, 2'b00};
    d_valid     = 1'b1;
    d_early_rs  = s.early;
    d_reads_rs  = s.rrs;
    d_reads_rt  = s.rrt;
    d_reg_write = s.rw;
    d_wr_sel    = s.wsel;
    d_is_load   = s.load;
    flush_d     = s.flush;
    mem_stall   = s.mstall;
    exp_q.push_back(s.exp);
  endtask

  task automatic idle();
    d_inst = '0; d_valid = 1'b0; d_early_rs = 1'b0; d_reads_rs = 1'b0; d_reads_rt = 1'b0;
    d_reg_write = 1'b0; d_wr_sel = 2'b00; d_is_load = 1'b0; flush_d = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    rst_n = 1'b0;
    // Early consumer of R0 while reset entries hold dest 0: only the valid bits prevent a stall.
    apply(mk(3'd0, 3'd0, 3'd0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0));
    #3;
    exp = exp_q.pop_front();
    n_checks++;
    if (stall_d !== exp) begin
      n_fail++;
      $display("FAIL reset_stall: stall_d=%b expected %b", stall_d, exp);
    end
    n_checks++;
    if (stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: stall_cnt=%0d expected 0", stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_alu_early();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd1, 3'd3, 3'd0, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0)); // ADD R3
    seq.push_back(mk(3'd3, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1)); // BEQZ R3
    seq.push_back(mk(3'd3, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL alu_early c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_load_early();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd4, 3'd2, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R2
    seq.push_back(mk(3'd2, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1)); // JR R2
    seq.push_back(mk(3'd2, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    seq.push_back(mk(3'd2, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL load_early c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd4, 3'd5, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R5
    seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 1)); // ADD R6,R1,R5
    seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 0));
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)); // independent filler
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    seq.push_back(mk(3'd4, 3'd5, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R5
    seq.push_back(mk(3'd0, 3'd0, 3'd1, 0, 1, 0, 1, 2'b01, 0, 0, 0, 0)); // independent ADD R1
    seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 0)); // ADD reads R5
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL load_use c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_jal();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0)); // JAL
    seq.push_back(mk(3'd7, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1)); // JR R7
    seq.push_back(mk(3'd7, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    seq.push_back(mk(3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0)); // JAL
    seq.push_back(mk(3'd7, 3'd0, 3'd0, 1, 0, 0, 1, 2'b11, 0, 1, 0, 0)); // flushed JALR R7
    seq.push_back(mk(3'd7, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0)); // JR R7: EX empty
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL jal c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_mem_stall();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd4, 3'd5, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R5
    repeat (3) seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 1, 1));
    seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 1));
    seq.push_back(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL mem_stall c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_load_gap();
    stim_t seq[$];
    logic  exp;
    seq.push_back(mk(3'd4, 3'd2, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R2
    seq.push_back(mk(3'd0, 3'd0, 3'd1, 0, 1, 0, 1, 2'b01, 0, 0, 0, 0)); // ADD R1
    seq.push_back(mk(3'd2, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1)); // JR R2 (load in MEM)
    seq.push_back(mk(3'd2, 3'd0, 3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (stall_d !== exp) begin
        n_fail++;
        $display("FAIL load_gap c%0d: stall_d=%b expected %b", i, stall_d, exp);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_perf_cnt(input int unsigned enabled_count);
    logic [CNT_W-1:0] exp_cnt;
`ifdef HAZ_PERF_CNT_EN
    exp_cnt = CNT_W'(enabled_count);
`else
    exp_cnt = CNT_W'(enabled_count * 0);
`endif
    n_checks++;
    if (stall_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL perf_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic exp;
    apply(mk(3'd4, 3'd5, 3'd0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 0)); // LD R5
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (stall_d !== exp) begin
      n_fail++;
      $display("FAIL rst_mid ld: stall_d=%b expected %b", stall_d, exp);
    end
    @(posedge clk);
    #1;
    apply(mk(3'd1, 3'd5, 3'd6, 0, 1, 1, 1, 2'b01, 0, 0, 0, 1)); // ADD reads R5
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (stall_d !== exp) begin
      n_fail++;
      $display("FAIL rst_mid pre: stall_d=%b expected %b", stall_d, exp);
    end
    #1;
    rst_n = 1'b0;
    exp_q.push_back(1'b0);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (stall_d !== exp) begin
      n_fail++;
      $display("FAIL rst_mid async: stall_d=%b expected %b", stall_d, exp);
    end
    n_checks++;
    if (stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_mid cnt: stall_cnt=%0d expected 0", stall_cnt);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(1'b0);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (stall_d !== exp) begin
      n_fail++;
      $display("FAIL rst_mid post: stall_d=%b expected %b", stall_d, exp);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_early();
    test_load_early();
    test_load_use();
    test_perf_cnt(4);
    test_jal();
    test_mem_stall();
    test_load_gap();
    test_perf_cnt(7);
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
